// File: rtl/multi_phase_signal_controller.sv
// Round-robin N-phase intersection sequencer with latched pedestrian requests.
// Optional protected left-turn interval ahead of phase 0 when LEFT_TURN_EN is defined.
module multi_phase_signal_controller #(
  parameter int NUM_PHASES    = 4,
  parameter int GREEN_TICKS   = 10,
  parameter int AMBER_TICKS   = 3,
  parameter int ALL_RED_TICKS = 2,
  parameter int WALK_TICKS    = 5,
  parameter int FLASH_TICKS   = 4,
  parameter int LEFT_TICKS    = 4,
  parameter int CNT_W         = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [NUM_PHASES-1:0]         walk_request,
  input  logic                          left_request,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         amber,
  output logic [NUM_PHASES-1:0]         red,
  output logic [NUM_PHASES-1:0]         walk,
  output logic [NUM_PHASES-1:0]         flashing_dont_walk,
  output logic [NUM_PHASES-1:0]         dont_walk,
  output logic                          left_arrow,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic [NUM_PHASES-1:0]         walk_request_waiting,
  output logic [2:0]                    state
);

  localparam int PW        = $clog2(NUM_PHASES);
  localparam int PED_TICKS = WALK_TICKS + FLASH_TICKS;
  localparam int EXT_TICKS = (GREEN_TICKS > PED_TICKS) ? GREEN_TICKS : PED_TICKS;

  localparam logic [CNT_W-1:0] GREEN_LD   = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] EXT_LD     = CNT_W'(EXT_TICKS - 1);
  localparam logic [CNT_W-1:0] AMBER_LD   = CNT_W'(AMBER_TICKS - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LD = CNT_W'(ALL_RED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LD    = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LD   = CNT_W'(FLASH_TICKS - 1);
  localparam logic [CNT_W-1:0] LEFT_LD    = CNT_W'(LEFT_TICKS - 1);
  localparam logic [PW-1:0]    LAST_PHASE = PW'(NUM_PHASES - 1);

  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    LEFT    = 3'd1,
    GREEN   = 3'd2,
    AMBER   = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    PED_WALK  = 2'd0,
    PED_FLASH = 2'd1,
    PED_DONE  = 2'd2
  } ped_t;

  state_t                  cur_state, nxt_state;
  ped_t                    ped, nxt_ped;
  logic [CNT_W-1:0]        cnt, nxt_cnt, ped_cnt, nxt_ped_cnt;
  logic [PW-1:0]           nxt_phase, next_in_turn, green_phase;
  logic                    grant, enter_green, enter_left, left_go;
  logic [NUM_PHASES-1:0]   clear_mask;

  assign next_in_turn = (active_phase == LAST_PHASE) ? '0 : active_phase + 1'b1;
  assign green_phase  = (cur_state == LEFT) ? '0 : next_in_turn;
  assign grant        = walk_request_waiting[green_phase] | walk_request[green_phase];
  assign state        = cur_state;

`ifdef LEFT_TURN_EN
  logic left_latch;
  assign left_go = left_latch && (next_in_turn == '0);
`else
  logic unused_left;
  assign left_go     = 1'b0;
  assign unused_left = left_request ^ enter_left;
`endif

  // The pedestrian sub-sequence runs off its own counter inside GREEN; a green exit overrides it.
  always_comb begin
    nxt_state   = cur_state;
    nxt_cnt     = cnt;
    nxt_phase   = active_phase;
    nxt_ped     = ped;
    nxt_ped_cnt = ped_cnt;
    enter_green = 1'b0;
    enter_left  = 1'b0;
    if (tick) begin
      if (cur_state == GREEN && ped != PED_DONE) begin
        if (ped_cnt == '0) begin
          if (ped == PED_WALK) begin
            nxt_ped     = PED_FLASH;
            nxt_ped_cnt = FLASH_LD;
          end else begin
            nxt_ped = PED_DONE;
          end
        end else begin
          nxt_ped_cnt = ped_cnt - 1'b1;
        end
      end
      if (cnt != '0) begin
        nxt_cnt = cnt - 1'b1;
      end else begin
        case (cur_state)
          ALL_RED: begin
            if (left_go) begin
              nxt_state  = LEFT;
              nxt_cnt    = LEFT_LD;
              nxt_phase  = '0;
              enter_left = 1'b1;
            end else begin
              enter_green = 1'b1;
            end
          end
          LEFT:  enter_green = 1'b1;
          GREEN: begin
            nxt_state = AMBER;
            nxt_cnt   = AMBER_LD;
            nxt_ped   = PED_DONE;
          end
          AMBER: begin
            nxt_state = ALL_RED;
            nxt_cnt   = ALL_RED_LD;
          end
          default: begin
            nxt_state = ALL_RED;
            nxt_cnt   = ALL_RED_LD;
          end
        endcase
      end
      if (enter_green) begin
        nxt_state   = GREEN;
        nxt_phase   = green_phase;
        nxt_cnt     = grant ? EXT_LD : GREEN_LD;
        nxt_ped     = grant ? PED_WALK : PED_DONE;
        nxt_ped_cnt = WALK_LD;
      end
    end
  end

  always_comb begin
    clear_mask = '0;
    if (enter_green) clear_mask[green_phase] = 1'b1;
  end

  // Outputs decode from the next-state values so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state            <= ALL_RED;
      cnt                  <= ALL_RED_LD;
      active_phase         <= LAST_PHASE;
      ped                  <= PED_DONE;
      ped_cnt              <= '0;
      walk_request_waiting <= '0;
      green                <= '0;
      amber                <= '0;
      red                  <= '1;
      walk                 <= '0;
      flashing_dont_walk   <= '0;
      dont_walk            <= '1;
      left_arrow           <= 1'b0;
`ifdef LEFT_TURN_EN
      left_latch           <= 1'b0;
`endif
    end else begin
      cur_state            <= nxt_state;
      cnt                  <= nxt_cnt;
      active_phase         <= nxt_phase;
      ped                  <= nxt_ped;
      ped_cnt              <= nxt_ped_cnt;
      walk_request_waiting <= (walk_request_waiting | walk_request) & ~clear_mask;
      green                <= '0;
      amber                <= '0;
      red                  <= '1;
      walk                 <= '0;
      flashing_dont_walk   <= '0;
      dont_walk            <= '1;
      if (nxt_state == GREEN) begin
        green[nxt_phase] <= 1'b1;
        red[nxt_phase]   <= 1'b0;
        if (nxt_ped == PED_WALK) begin
          walk[nxt_phase]      <= 1'b1;
          dont_walk[nxt_phase] <= 1'b0;
        end else if (nxt_ped == PED_FLASH) begin
          flashing_dont_walk[nxt_phase] <= 1'b1;
          dont_walk[nxt_phase]          <= 1'b0;
        end
      end else if (nxt_state == AMBER) begin
        amber[nxt_phase] <= 1'b1;
        red[nxt_phase]   <= 1'b0;
      end
`ifdef LEFT_TURN_EN
      left_arrow <= (nxt_state == LEFT);
      left_latch <= (left_latch | left_request) & ~enter_left;
`else
      left_arrow <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/multi_phase_signal_controller.md
# multi_phase_signal_controller

Parametrised intersection sequencer generalising the fixed four-approach controller to `NUM_PHASES` conflicting phases, with per-phase latched pedestrian requests, configurable durations and an optional protected left-turn interval ahead of phase 0. It is driven by the divided clock plus a one-cycle `tick` enable. Its one-hot light and walk outputs feed the existing hex light and walk display decoders unchanged, one decoder set per phase.

## Interface
- `NUM_PHASES`, 4: number of phases served round-robin, 2..8.
- `GREEN_TICKS`, 10: minimum green duration in ticks.
- `AMBER_TICKS`, 3: amber duration in ticks.
- `ALL_RED_TICKS`, 2: all-red clearance between phases, in ticks.
- `WALK_TICKS`, 5: steady walk duration in ticks.
- `FLASH_TICKS`, 4: flashing don't-walk duration in ticks.
- `LEFT_TICKS`, 4: protected left-arrow duration in ticks.
- `CNT_W`, 8: width of the duration counter. Every `*_TICKS` value and `WALK_TICKS+FLASH_TICKS` must fit in it, and every `*_TICKS` is ≥1.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-cycle time-base enable; the counter advances only on cycles where it is high.
- `walk_request` in NUM_PHASES: per-phase pedestrian request (level or pulse).
- `left_request` in 1: protected-left request for phase 0.
- `green`, `amber`, `red` out NUM_PHASES: per-phase vehicle lights, one-hot per phase.
- `walk`, `flashing_dont_walk`, `dont_walk` out NUM_PHASES: per-phase pedestrian state, one-hot per phase.
- `left_arrow` out 1: protected left arrow for phase 0.
- `active_phase` out $clog2(NUM_PHASES): phase currently owning the FSM.
- `walk_request_waiting` out NUM_PHASES: latched, unserved requests (debug).
- `state` out 3: FSM state encoding (debug).

## Operation
- States: `ALL_RED`, `LEFT`, `GREEN`, `AMBER`. Each state loads the counter with `duration-1` on entry.
- Transitions:
  - `ALL_RED` → `LEFT` if the next phase is 0 and the left latch is set; otherwise `ALL_RED` → `GREEN` of the next phase, where next = `(active_phase+1) mod NUM_PHASES`.
  - `LEFT` → `GREEN` (phase 0).
  - `GREEN` → `AMBER` → `ALL_RED`.
- `GREEN` duration: `GREEN_TICKS`, or `max(GREEN_TICKS, WALK_TICKS+FLASH_TICKS)` when a walk is granted.
- Walk grant: if the request latch for phase p is set on the cycle of entry into `GREEN` p, or `walk_request[p]` is high on that cycle, then:
  - `walk[p]` is high for the first `WALK_TICKS` ticks, then `flashing_dont_walk[p]` for `FLASH_TICKS` ticks, then `dont_walk[p]`.
  - The latch for p clears on that entry cycle.
- Any request for p arriving after grant entry re-latches and is served on p's next green.
- The left latch sets on `left_request` and clears on entry to `LEFT`.
- Light outputs:
  - Only `active_phase` can show `green` or `amber`. All other phases show `red`.
  - In `LEFT`, phase 0 shows `red` with `left_arrow`=1.
  - In `ALL_RED`, every phase shows `red`.
- Outputs are registered and one-hot per phase at all times. No phase ever shows a walk state while another phase is green.

## Timing
- Reset values:
  - state=`ALL_RED`, counter=`ALL_RED_TICKS-1`, `active_phase`=`NUM_PHASES-1`.
  - `red`=all ones, `dont_walk`=all ones.
  - `green`, `amber`, `walk`, `flashing_dont_walk`, `left_arrow` = 0. All latches = 0.
- A state lasts exactly its duration in ticks. The transition occurs on the clock edge where `tick`=1 and counter=0.
- Outputs reflect the new state on the cycle after that edge (one-cycle registered latency).
- A request that is high on the same cycle as its latch clear is treated as served. It does not re-latch.
- `reset` asserted mid-sequence returns the block to reset values on the next edge, regardless of `tick`.
- `tick` held high on consecutive cycles is legal and makes each cycle count as one tick.

## Configuration
- `LEFT_TURN_EN`
  - Defined: `LEFT` state, left latch and `left_arrow` are present as described.
  - Undefined: `LEFT` state is removed, `left_request` is ignored, `left_arrow` is tied to 0, and `ALL_RED` always goes directly to `GREEN`.

## Test plan
- Reset with `NUM_PHASES`=4 and `tick` every cycle, no requests → phases 0,1,2,3,0 each show green 10, amber 3, all-red 2 cycles. `walk` is never high.
- Pulse `walk_request[2]` during phase 0 green → `walk_request_waiting[2]`=1. On entry to phase 2 green, `walk[2]` is high 5 ticks and `flashing_dont_walk[2]` 4 ticks. Green lasts 10 ticks and the latch clears.
- `WALK_TICKS`=8, `FLASH_TICKS`=6, request on phase 1 → phase 1 green extends to 14 ticks. Other phases keep 10.
- `LEFT_TURN_EN` defined, `left_request` pulsed during phase 2 → after phase 3 all-red, `left_arrow`=1 for 4 ticks with phase 0 red, then phase 0 green. Without the macro, `left_arrow` stays 0.
- Assert `reset` during phase 1 amber → the next cycle shows all red, all `dont_walk`, `active_phase`=3, and latches clear.
- `tick` every 5th cycle → every state duration scales ×5. Every cycle has all per-phase outputs one-hot and at most one phase non-red.
